// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: command-driven access controller for a 2-read/1-write register file.
//
// Accepts NOP/WRITE/READ2/MOVE commands over a valid/ready handshake and drives the
// register file write and read ports. READ2 results return over a second valid/ready
// handshake. MOVE reads src0 at accept and writes it to dst one cycle later.
//
// Ports:
//   clk, rst_n_i                 clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o    command handshake
//   cmd_op_i                     00 NOP, 01 WRITE, 10 READ2, 11 MOVE
//   cmd_dst_i, cmd_src0_i,
//   cmd_src1_i, cmd_data_i       command operands
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_data0_o, rsp_data1_o     READ2 results
//   rf_wen_o, rf_wa_o, rf_wd_o   register file write port
//   rf_ra0_o, rf_ra1_o           register file read addresses
//   rf_rd0_i, rf_rd1_i           register file read data (combinational)
//   done_cnt_o                   completed non-NOP command count (wraps)
module regfile_port_ctrl #(
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 4,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [1:0]    cmd_op_i,
  input  logic [AW-1:0] cmd_dst_i,
  input  logic [AW-1:0] cmd_src0_i,
  input  logic [AW-1:0] cmd_src1_i,
  input  logic [W-1:0]  cmd_data_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [W-1:0]  rsp_data0_o,
  output logic [W-1:0]  rsp_data1_o,
  output logic          rf_wen_o,
  output logic [AW-1:0] rf_wa_o,
  output logic [W-1:0]  rf_wd_o,
  output logic [AW-1:0] rf_ra0_o,
  output logic [AW-1:0] rf_ra1_o,
  input  logic [W-1:0]  rf_rd0_i,
  input  logic [W-1:0]  rf_rd1_i,
  output logic [CW-1:0] done_cnt_o
);

  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRead2 = 2'b10;
  localparam logic [1:0] OpMove  = 2'b11;

  typedef enum logic [1:0] {StIdle, StResp, StMoveWr} state_e;

  state_e        state_q;
  logic          rsp_valid_q;
  logic [W-1:0]  rsp_data0_q;
  logic [W-1:0]  rsp_data1_q;
  logic [AW-1:0] hold_addr_q;
  logic [W-1:0]  hold_data_q;
  logic [AW-1:0] ra0_q;
  logic [AW-1:0] ra1_q;
  logic [CW-1:0] done_cnt_q;

  logic idle;
  logic accept;

  assign idle        = (state_q == StIdle);
  // Gated by the reset pin so ready drops asynchronously while reset is held.
  assign cmd_ready_o = idle & rst_n_i;
  assign accept      = cmd_valid_i & cmd_ready_o;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data0_o = rsp_data0_q;
  assign rsp_data1_o = rsp_data1_q;
  assign done_cnt_o  = done_cnt_q;

  // Read addresses follow the command bus while ready, otherwise hold the last accepted ones.
  assign rf_ra0_o = cmd_ready_o ? cmd_src0_i : ra0_q;
  assign rf_ra1_o = cmd_ready_o ? cmd_src1_i : ra1_q;

  // WRITE goes straight through on the accept cycle; MOVE writes from the hold registers.
  always_comb begin
    rf_wen_o = 1'b0;
    rf_wa_o  = '0;
    rf_wd_o  = '0;
    if (accept && (cmd_op_i == OpWrite)) begin
      rf_wen_o = 1'b1;
      rf_wa_o  = cmd_dst_i;
      rf_wd_o  = cmd_data_i;
    end else if (state_q == StMoveWr) begin
      rf_wen_o = 1'b1;
      rf_wa_o  = hold_addr_q;
      rf_wd_o  = hold_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      rsp_valid_q <= 1'b0;
      rsp_data0_q <= '0;
      rsp_data1_q <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      ra0_q       <= '0;
      ra1_q       <= '0;
      done_cnt_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            ra0_q <= cmd_src0_i;
            ra1_q <= cmd_src1_i;
            unique case (cmd_op_i)
              OpNop: ;
              OpWrite: done_cnt_q <= done_cnt_q + CW'(1);
              OpRead2: begin
                rsp_data0_q <= rf_rd0_i;
                rsp_data1_q <= rf_rd1_i;
                rsp_valid_q <= 1'b1;
                state_q     <= StResp;
              end
              OpMove: begin
                hold_data_q <= rf_rd0_i;
                hold_addr_q <= cmd_dst_i;
                state_q     <= StMoveWr;
              end
            endcase
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            done_cnt_q  <= done_cnt_q + CW'(1);
            state_q     <= StIdle;
          end
        end
        StMoveWr: begin
          done_cnt_q <= done_cnt_q + CW'(1);
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Self-checking bench for regfile_port_ctrl. A behavioural register-file array and
// a command-level reference model (register contents + completed-command count)
// predict every response, write-port value and counter value.
module tb_regfile_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_dst, cmd_src0, cmd_src1;
  logic [15:0] cmd_data;
  logic        rsp_ready;

  logic        cmd_ready, rsp_valid, rf_wen;
  logic [15:0] rsp_data0, rsp_data1, rf_wd, rf_rd0, rf_rd1, done_cnt;
  logic [3:0]  rf_wa, rf_ra0, rf_ra1;

  logic        d2_cmd_ready, d2_rsp_valid, d2_rf_wen;
  logic [15:0] d2_rsp_data0, d2_rsp_data1, d2_rf_wd, d2_rf_rd0, d2_rf_rd1;
  logic [3:0]  d2_rf_wa, d2_rf_ra0, d2_rf_ra1;
  logic [1:0]  d2_done_cnt;

  logic [15:0] rf  [16] = '{default: '0};
  logic [15:0] rf2 [16] = '{default: '0};

  // Reference model state.
  logic [15:0] mdl [16] = '{default: '0};
  int unsigned cnt_m;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_port_ctrl #(.W(16), .AW(4), .CW(16)) u_dut (
    .clk(clk), .rst_n_i(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_dst_i(cmd_dst), .cmd_src0_i(cmd_src0), .cmd_src1_i(cmd_src1),
    .cmd_data_i(cmd_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data0_o(rsp_data0), .rsp_data1_o(rsp_data1), .rf_wen_o(rf_wen), .rf_wa_o(rf_wa),
    .rf_wd_o(rf_wd), .rf_ra0_o(rf_ra0), .rf_ra1_o(rf_ra1), .rf_rd0_i(rf_rd0),
    .rf_rd1_i(rf_rd1), .done_cnt_o(done_cnt)
  );

  // Narrow-counter instance sharing the same command stream, used for wrap checks.
  regfile_port_ctrl #(.W(16), .AW(4), .CW(2)) u_dut2 (
    .clk(clk), .rst_n_i(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(d2_cmd_ready),
    .cmd_op_i(cmd_op), .cmd_dst_i(cmd_dst), .cmd_src0_i(cmd_src0), .cmd_src1_i(cmd_src1),
    .cmd_data_i(cmd_data), .rsp_valid_o(d2_rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data0_o(d2_rsp_data0), .rsp_data1_o(d2_rsp_data1), .rf_wen_o(d2_rf_wen),
    .rf_wa_o(d2_rf_wa), .rf_wd_o(d2_rf_wd), .rf_ra0_o(d2_rf_ra0), .rf_ra1_o(d2_rf_ra1),
    .rf_rd0_i(d2_rf_rd0), .rf_rd1_i(d2_rf_rd1), .done_cnt_o(d2_done_cnt)
  );

  assign rf_rd0    = rf[rf_ra0];
  assign rf_rd1    = rf[rf_ra1];
  assign d2_rf_rd0 = rf2[d2_rf_ra0];
  assign d2_rf_rd1 = rf2[d2_rf_ra1];

  always @(posedge clk) begin
    if (rf_wen) rf[rf_wa] <= rf_wd;
    if (d2_rf_wen) rf2[d2_rf_wa] <= d2_rf_wd;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
  endtask

  // Reset pulse issued between clock edges; the model forgets only the counter.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cnt_m = 0;
    #1;
  endtask

  task automatic do_write(input logic [3:0] dst, input logic [15:0] data);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_dst = dst; cmd_data = data;
    #1;
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready: got %b want 1", cmd_ready); end
    n_vec++; if ({rf_wen, rf_wa, rf_wd} !== {1'b1, dst, data}) begin
      n_err++; $display("FAIL wr_port: got wen=%b wa=%0d wd=%0h want wen=1 wa=%0d wd=%0h",
                        rf_wen, rf_wa, rf_wd, dst, data);
    end
    tick();
    idle_inputs();
    mdl[dst] = data;
    cnt_m++;
    n_vec++; if (done_cnt !== 16'(cnt_m)) begin n_err++; $display("FAIL wr_cnt: got %0d want %0d", done_cnt, 16'(cnt_m)); end
  endtask

  task automatic do_nop();
    cmd_valid = 1'b1; cmd_op = 2'b00;
    #1;
    n_vec++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL nop_wen: got %b want 0", rf_wen); end
    tick();
    idle_inputs();
    n_vec++; if ({done_cnt, cmd_ready, rsp_valid} !== {16'(cnt_m), 1'b1, 1'b0}) begin
      n_err++; $display("FAIL nop_state: got cnt=%0d rdy=%b rv=%b want cnt=%0d rdy=1 rv=0",
                        done_cnt, cmd_ready, rsp_valid, 16'(cnt_m));
    end
  endtask

  // READ2 with `stall` cycles of rsp_ready low; when `poke` a WRITE is offered during the stall.
  task automatic do_read2(input logic [3:0] s0, input logic [3:0] s1, input int stall,
                          input bit poke);
    logic [15:0] e0, e1;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_src0 = s0; cmd_src1 = s1; rsp_ready = 1'b0;
    #1;
    n_vec++; if ({cmd_ready, rf_ra0, rf_ra1} !== {1'b1, s0, s1}) begin
      n_err++; $display("FAIL rd_addr: got rdy=%b ra0=%0d ra1=%0d want rdy=1 ra0=%0d ra1=%0d",
                        cmd_ready, rf_ra0, rf_ra1, s0, s1);
    end
    e0 = mdl[s0];
    e1 = mdl[s1];
    tick();
    idle_inputs();
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_dst = s0; cmd_data = 16'hdead;
      end
      #1;
      n_vec++; if ({rsp_valid, rsp_data0, rsp_data1, cmd_ready, rf_wen} !== {1'b1, e0, e1, 1'b0, 1'b0}) begin
        n_err++; $display("FAIL rd_stall: got rv=%b d0=%0h d1=%0h rdy=%b wen=%b want rv=1 d0=%0h d1=%0h rdy=0 wen=0",
                          rsp_valid, rsp_data0, rsp_data1, cmd_ready, rf_wen, e0, e1);
      end
      tick();
    end
    idle_inputs();
    #1;
    n_vec++; if ({rsp_valid, rsp_data0, rsp_data1} !== {1'b1, e0, e1}) begin
      n_err++; $display("FAIL rd_rsp: got rv=%b d0=%0h d1=%0h want rv=1 d0=%0h d1=%0h",
                        rsp_valid, rsp_data0, rsp_data1, e0, e1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cnt_m++;
    n_vec++; if ({rsp_valid, cmd_ready, done_cnt} !== {1'b0, 1'b1, 16'(cnt_m)}) begin
      n_err++; $display("FAIL rd_done: got rv=%b rdy=%b cnt=%0d want rv=0 rdy=1 cnt=%0d",
                        rsp_valid, cmd_ready, done_cnt, 16'(cnt_m));
    end
  endtask

  task automatic do_move(input logic [3:0] src, input logic [3:0] dst);
    logic [15:0] v;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_src0 = src; cmd_dst = dst;
    #1;
    n_vec++; if ({cmd_ready, rf_wen} !== 2'b10) begin
      n_err++; $display("FAIL mv_accept: got rdy=%b wen=%b want rdy=1 wen=0", cmd_ready, rf_wen);
    end
    v = mdl[src];
    tick();
    idle_inputs();
    n_vec++; if ({rf_wen, rf_wa, rf_wd, rsp_valid} !== {1'b1, dst, v, 1'b0}) begin
      n_err++; $display("FAIL mv_write: got wen=%b wa=%0d wd=%0h rv=%b want wen=1 wa=%0d wd=%0h rv=0",
                        rf_wen, rf_wa, rf_wd, rsp_valid, dst, v);
    end
    tick();
    mdl[dst] = v;
    cnt_m++;
    n_vec++; if ({rf_wen, cmd_ready, done_cnt} !== {1'b0, 1'b1, 16'(cnt_m)}) begin
      n_err++; $display("FAIL mv_done: got wen=%b rdy=%b cnt=%0d want wen=0 rdy=1 cnt=%0d",
                        rf_wen, cmd_ready, done_cnt, 16'(cnt_m));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b01;
    cmd_dst = 4'd3; cmd_src0 = 4'd5; cmd_src1 = 4'd6; cmd_data = 16'h1234;
    #3;
    n_vec++; if ({cmd_ready, rsp_valid, rsp_data0, rsp_data1, rf_wen, rf_wa, rf_wd, rf_ra0, rf_ra1, done_cnt} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got rdy=%b rv=%b wen=%b wa=%0d wd=%0h ra0=%0d ra1=%0d cnt=%0d want all 0",
                        cmd_ready, rsp_valid, rf_wen, rf_wa, rf_wd, rf_ra0, rf_ra1, done_cnt);
    end
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    cnt_m = 0;
    #1;
    n_vec++; if ({cmd_ready, done_cnt} !== {1'b1, 16'd0}) begin
      n_err++; $display("FAIL reset_release: got rdy=%b cnt=%0d want rdy=1 cnt=0", cmd_ready, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_write(4'd0, 16'd10);
    do_write(4'd1, 16'd20);
    do_read2(4'd1, 4'd1, 0, 1'b0);
    n_vec++; if (done_cnt !== 16'd3) begin n_err++; $display("FAIL b2b_cnt: got %0d want 3", done_cnt); end
  endtask

  task automatic test_resp_stall();
    do_read2(4'd0, 4'd1, 5, 1'b1);
    n_vec++; if (rf[0] !== 16'd10) begin n_err++; $display("FAIL stall_nowrite: got r0=%0d want 10", rf[0]); end
  endtask

  task automatic test_move();
    do_move(4'd1, 4'd5);
    do_read2(4'd5, 4'd1, 1, 1'b0);
    n_vec++; if (rf[5] !== 16'd20) begin n_err++; $display("FAIL move_r5: got %0d want 20", rf[5]); end
  endtask

  task automatic test_reset_in_resp();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_src0 = 4'd0; cmd_src1 = 4'd1; rsp_ready = 1'b0;
    tick();
    idle_inputs();
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rresp_pending: got %b want 1", rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({cmd_ready, rsp_valid, rsp_data0, rsp_data1, rf_wen, rf_ra0, rf_ra1, done_cnt} !== '0) begin
      n_err++; $display("FAIL rresp_async: got rdy=%b rv=%b d0=%0h d1=%0h wen=%b cnt=%0d want all 0",
                        cmd_ready, rsp_valid, rsp_data0, rsp_data1, rf_wen, done_cnt);
    end
    tick();
    rst_n = 1'b1;
    cnt_m = 0;
    #1;
    n_vec++; if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_err++; $display("FAIL rresp_after: got rdy=%b rv=%b want rdy=1 rv=0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_in_move();
    do_write(4'd7, 16'd3);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_src0 = 4'd0; cmd_dst = 4'd7;
    tick();
    idle_inputs();
    n_vec++; if (rf_wen !== 1'b1) begin n_err++; $display("FAIL rmove_wen: got %b want 1", rf_wen); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL rmove_abort: got wen=%b want 0", rf_wen); end
    tick();
    rst_n = 1'b1;
    cnt_m = 0;
    #1;
    do_read2(4'd7, 4'd0, 0, 1'b0);
    n_vec++; if (rsp_data0 !== 16'd3) begin n_err++; $display("FAIL rmove_r7: got %0d want 3", rsp_data0); end
  endtask

  task automatic test_counter_wrap();
    logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      do_write(4'(i + 8), 16'(100 + i));
      n_vec++; if (d2_done_cnt !== seq[i]) begin
        n_err++; $display("FAIL wrap_cnt%0d: got %0d want %0d", i, d2_done_cnt, seq[i]);
      end
      do_nop();
      n_vec++; if (d2_done_cnt !== seq[i]) begin
        n_err++; $display("FAIL wrap_nop%0d: got %0d want %0d", i, d2_done_cnt, seq[i]);
      end
    end
  endtask

  task automatic test_random();
    int unsigned op;
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 3);
      rsp_ready = 1'($urandom_range(0, 1));  // must be ignored while no response is pending
      case (op)
        0: do_nop();
        1: do_write(4'($urandom_range(0, 15)), 16'($urandom));
        2: do_read2(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        default: do_move(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      endcase
      rsp_ready = 1'b0;
      n_vec++; if (d2_done_cnt !== 2'(cnt_m)) begin
        n_err++; $display("FAIL rnd_cnt2: got %0d want %0d", d2_done_cnt, 2'(cnt_m));
      end
    end
    for (int a = 0; a < 16; a++) begin
      n_vec++; if (rf[a] !== mdl[a]) begin
        n_err++; $display("FAIL rnd_rf%0d: got %0h want %0h", a, rf[a], mdl[a]);
      end
    end
  endtask

  initial begin
    cnt_m = 0;
    test_reset();
    test_back_to_back();
    test_resp_stall();
    test_move();
    test_reset_in_resp();
    test_reset_in_move();
    test_counter_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Command-driven access controller for the 2-read/1-write register file. It accepts write, dual-read and register-to-register move commands over a valid/ready handshake and drives the register file's write and read ports. Read results come back over a second valid/ready handshake. It sits between a sequencer or host and the `register` instance, acting as the initiator that the register file responds to.

## Interface
- W, 16, data width of the register file and of the response data.
- AW, 4, register address width (2^AW registers).
- CW, 16, width of the completed-command counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  controller can accept a command.
- cmd_op_i  in  2  opcode: 00 NOP, 01 WRITE, 10 READ2, 11 MOVE.
- cmd_dst_i  in  AW  write address (WRITE, MOVE).
- cmd_src0_i  in  AW  read address 0 (READ2, MOVE source).
- cmd_src1_i  in  AW  read address 1 (READ2).
- cmd_data_i  in  W  write data (WRITE).
- rsp_valid_o  out  1  read response present.
- rsp_ready_i  in  1  consumer takes response.
- rsp_data0_o  out  W  value read from src0.
- rsp_data1_o  out  W  value read from src1.
- rf_wen_o  out  1  register file write enable.
- rf_wa_o  out  AW  register file write address.
- rf_wd_o  out  W  register file write data.
- rf_ra0_o  out  AW  register file read address 0.
- rf_ra1_o  out  AW  register file read address 1.
- rf_rd0_i  in  W  register file read data 0 (combinational from rf_ra0_o).
- rf_rd1_i  in  W  register file read data 1 (combinational from rf_ra1_o).
- done_cnt_o  out  CW  count of completed non-NOP commands.

## Operation
- FSM states: IDLE, RESP, MOVE_WR. Reset state IDLE.
- cmd_ready_o = 1 only in IDLE with rst_n_i high. Accept = cmd_valid_i & cmd_ready_o.
- rf_ra0_o/rf_ra1_o = cmd_src0_i/cmd_src1_i in IDLE. They hold the last accepted values in other states.
- NOP accepted: no effect, counter unchanged, stays IDLE.
- WRITE accepted: in the same cycle, rf_wen_o=1, rf_wa_o=cmd_dst_i, rf_wd_o=cmd_data_i (combinational). The register file writes on that edge. Counter +1. Stays IDLE.
- READ2 accepted: on the accept edge, rsp_data0_o<=rf_rd0_i and rsp_data1_o<=rf_rd1_i; rsp_valid_o<=1; go to RESP.
- RESP: hold rsp_valid_o and the data stable until rsp_ready_i=1. On that edge: rsp_valid_o<=0, counter +1, go to IDLE.
- MOVE accepted: on the accept edge, capture rf_rd0_i into hold register and cmd_dst_i into hold address; go to MOVE_WR.
- MOVE_WR: rf_wen_o=1, rf_wa_o=hold address, rf_wd_o=hold data for exactly one cycle. Then counter +1 and go to IDLE. No response is produced.
- rf_wen_o=0 in every other case. rf_wa_o/rf_wd_o are don't-care when rf_wen_o=0 but must be driven (no X).
- MOVE with src0==dst rewrites the same value. This is legal.
- READ2 with src0==src1 returns identical data on both fields.
- done_cnt_o wraps from 2^CW-1 to 0 without saturation.
- Unknown behaviour is not permitted. All 4 opcodes are defined.

## Timing
- Reset (rst_n_i low, asynchronous) sets: state IDLE, cmd_ready_o 0, rsp_valid_o 0, rsp_data0_o/rsp_data1_o 0, rf_wen_o 0, rf_wa_o/rf_wd_o/rf_ra0_o/rf_ra1_o 0, done_cnt_o 0, hold registers 0.
- Reset asserted in RESP drops the pending response. Reset in MOVE_WR aborts the write: rf_wen_o falls immediately and the destination is not modified.
- Latencies: WRITE takes effect at the accept edge, so a READ2 of that address in the following cycle returns the new value. READ2 gives rsp_valid_o 1 cycle after accept. MOVE writes 1 cycle after accept.
- Throughput: WRITE/NOP 1 per cycle. READ2 is at least 2 cycles (accept + response handshake). MOVE is 2 cycles.
- Response handshake: once rsp_valid_o is set, it and the data must not change until rsp_ready_i is sampled high. A rsp_ready_i high while rsp_valid_o=0 is ignored.
- Read data is sampled only at the accept edge. Register file changes after that do not alter a pending response.

## Test plan
- Reset: hold rst_n_i low mid-sim with rsp_valid_o=1 → all outputs 0 asynchronously. After release, cmd_ready_o=1 and done_cnt_o=0.
- Back-to-back WRITE r0=10 then r1=20, then READ2 src0=1,src1=1 → rf_wen_o high two consecutive cycles. The response is 20/20 one cycle after accept, and done_cnt_o=3 after the response handshake.
- Response stall: READ2 src0=0,src1=1 with rsp_ready_i low for 5 cycles → rsp_valid_o and 10/20 stay stable and cmd_ready_o=0. Meanwhile a cmd_valid_i WRITE is not accepted. After rsp_ready_i pulses, state returns to IDLE.
- MOVE r1→r5, then READ2 src0=5,src1=1 → rf_wen_o=1 with wa=5, wd=20 exactly one cycle after accept, and the response is 20/20.
- Reset in MOVE_WR: MOVE r0→r7 (r7=3 beforehand), assert rst_n_i during MOVE_WR → rf_wen_o falls immediately, and a later READ2 src0=7 returns 3.
- Counter wrap with CW=2: perform 5 WRITEs → done_cnt_o sequence 1,2,3,0,1. NOPs interleaved leave the count unchanged.
